lc3_alu_seq: RTL and testbench
==============================

// Module: lc3_alu_seq
// PURPOSE
//  Parametrised, registered successor to the LC-3 datapath ALU.
//  - Adds XOR, logical shift-left, arithmetic shift-right and an iterative shift-add multiply.
//  - Registers the result together with LC-3 condition codes (NZP).
//  - Uses a start/busy/done handshake with the control FSM.
//  - Drives the shared data bus tri-state from the result register while gate_alu is high.
// PARAMETERS
//  WIDTH   16  datapath width in bits (>= 8; power of two)
//  IMM_W   5   immediate field width in ir; imm = sign-extended ir[IMM_W-1:0]
//  MUL_EN  1   1: op 3'b111 is multiply; 0: op 3'b111 is single-cycle PASSA
// PORTS
//  clk       in   1      single clock; all state on rising edge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      launch operation; sampled only when FSM is IDLE
//  aluk      in   3      op: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 XOR, 101 SHL, 110 SRA, 111 MUL
//  sr1out    in   WIDTH  operand A
//  ir        in   WIDTH  instruction; ir[5]=1 selects immediate as operand B
//  sr2out    in   WIDTH  operand B when ir[5]=0
//  gate_alu  in   1      1: data_bus = result; 0: data_bus = all Z
//  busy      out  1      multiply in progress
//  done      out  1      one-cycle pulse: result/nzp updated
//  result    out  WIDTH  registered result
//  nzp       out  3      {N,Z,P} of result, registered with result
//  data_bus  out  WIDTH  tri-state bus driver
// BEHAVIOUR
//  Reset (sync, wins over everything)
//   - result=0, nzp=3'b010, busy=0, done=0, FSM=IDLE, iteration counter=0.
//   - Reset during MUL aborts the operation; no done is produced.
//  Operand B
//   - op_b = ir[5] ? {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]} : sr2out.
//   - Operands and aluk are captured at the accepting edge; later input changes are ignored.
//  Arithmetic (all results truncated to WIDTH bits, no carry/overflow outputs)
//   - ADD: A+B modulo 2^WIDTH.  AND / XOR: bitwise.  NOT: ~A.  PASSA: A.
//   - SHL: A << op_b[$clog2(WIDTH)-1:0], zero fill.
//   - SRA: A >>> op_b[$clog2(WIDTH)-1:0], sign fill.
//   - MUL: low WIDTH bits of A*B (unsigned shift-add; low bits equal the two's-complement product).
//  FSM states: IDLE, MUL
//   - IDLE & start & op!=MUL (or MUL_EN=0)
//     - result and nzp are written at edge T; done=1 for cycle T+1; busy stays 0.
//   - IDLE & start & op==MUL & MUL_EN=1
//     - Operands are captured at edge T; go to MUL.
//     - busy=1 for cycles T+1..T+WIDTH; one multiplier bit is consumed per edge.
//     - WIDTH iterations in total.
//     - result and nzp are written at edge T+WIDTH; FSM returns to IDLE; done=1 for cycle T+WIDTH+1.
//   - start while busy is ignored (not queued). start in a done cycle is accepted (FSM is IDLE).
//  Condition codes
//   - nzp = 100 if result[WIDTH-1]; 010 if result==0; 001 otherwise. Exactly one bit is set.
//  Visibility
//   - result and nzp hold their value until the next completed operation.
//   - During MUL, result is the previous value; partial products are never exposed.
//  data_bus
//   - Combinational from gate_alu and the registered result.
//   - gate_alu is independent of the busy state.
// TESTING
//  - ADD imm: sr1out=16'h0005, ir[5]=1, ir[4:0]=5'b11101, start -> next cycle result=16'h0002, nzp=001, done=1 for 1 cycle, busy=0.
//  - ADD overflow / NOT: 16'h7FFF + sr2out 16'h0001 -> 16'h8000, nzp=100; NOT 16'h00FF -> 16'hFF00, nzp=100.
//  - Shifts: SRA 16'h8000 by 4 -> 16'hF800; SHL 16'h0003 by 15 -> 16'h8000; shift amount uses only op_b[3:0].
//  - MUL: 16'h0013 * 16'h0005 -> busy for 16 cycles, result=16'h005F, nzp=001, done at T+17; start pulsed mid-busy is ignored.
//  - Reset mid-MUL: assert reset at cycle T+5 -> next cycle busy=0, result=0, nzp=010; done never pulses.
//  - Bus: gate_alu=0 -> data_bus all Z; gate_alu=1 -> data_bus=result, including while busy (shows the old result).

Source files
------------

// File: rtl/lc3_alu_seq.sv
// Registered LC-3 ALU with XOR, shifts and an iterative shift-add multiply.
// Single-cycle ops finish on the accepting edge; MUL runs one multiplier bit per clock.
module lc3_alu_seq #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 5,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluk,
  input  logic [WIDTH-1:0] sr1out,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] sr2out,
  input  logic             gate_alu,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output wire  [WIDTH-1:0] data_bus
);

  // state  | meaning
  // S_IDLE | waiting for start; single-cycle ops complete on the accepting edge
  // S_MUL  | shift-add multiply in progress, one multiplier bit per edge
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  acc, mcand, mplier, acc_nxt;
  logic [WIDTH-1:0]  op_b, alu_res;
  logic [SH_W-1:0]   sh_amt;
  logic              is_mul_op, wr_alu, load_mul, mul_step, mul_last;
  logic              unused_ir;

  function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] r);
    if (r[WIDTH-1])    return 3'b100;
    else if (r == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  assign unused_ir = ^ir;
  assign op_b      = ir[5] ? {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]} : sr2out;
  assign sh_amt    = op_b[SH_W-1:0];
  assign is_mul_op = (MUL_EN != 0) && (aluk == 3'b111);
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = sr1out;
    case (aluk)
      3'b000:  alu_res = sr1out + op_b;
      3'b001:  alu_res = sr1out & op_b;
      3'b010:  alu_res = ~sr1out;
      3'b011:  alu_res = sr1out;
      3'b100:  alu_res = sr1out ^ op_b;
      3'b101:  alu_res = sr1out << sh_amt;
      3'b110:  alu_res = $unsigned($signed(sr1out) >>> sh_amt);
      default: alu_res = sr1out;  // PASSA when the multiplier is disabled
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_alu    = 1'b0;
    load_mul  = 1'b0;
    mul_step  = 1'b0;
    mul_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_mul_op) begin
            load_mul  = 1'b1;
            state_nxt = S_MUL;
          end else begin
            wr_alu = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (cnt == '0) begin
          mul_last  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      nzp    <= 3'b010;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      done <= 1'b0;
      if (wr_alu) begin
        result <= alu_res;
        nzp    <= calc_nzp(alu_res);
        done   <= 1'b1;
      end
      if (load_mul) begin
        acc    <= '0;
        mcand  <= sr1out;
        mplier <= op_b;
        cnt    <= CNT_W'(WIDTH-1);
      end
      // partial products stay internal; result only changes on the last step
      if (mul_step) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (mul_last) begin
          result <= acc_nxt;
          nzp    <= calc_nzp(acc_nxt);
          done   <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign busy     = (state == S_MUL);
  assign data_bus = gate_alu ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Randomized and directed bench for lc3_alu_seq against an arithmetic reference model.
module tb_lc3_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start, gate_alu;
  logic [2:0]  aluk;
  logic [15:0] sr1out, ir, sr2out;
  logic        busy, done;
  logic [15:0] result;
  logic [2:0]  nzp;
  wire  [15:0] data_bus;
  logic        tb_drv_en;
  logic [15:0] tb_drv_val;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_result;
  logic [2:0]  model_nzp;

  assign data_bus = tb_drv_en ? tb_drv_val : 16'hzzzz;

  lc3_alu_seq #(.WIDTH(16), .IMM_W(5), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .aluk(aluk),
    .sr1out(sr1out), .ir(ir), .sr2out(sr2out), .gate_alu(gate_alu),
    .busy(busy), .done(done), .result(result), .nzp(nzp), .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_op_b(input logic [15:0] i_r, input logic [15:0] b2);
    int v;
    if (!i_r[5]) return b2;
    v = int'(i_r) % 32;
    if (v >= 16) v = v - 32;
    return 16'(v);
  endfunction

  function automatic logic [15:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    int unsigned ua, ub;
    int s, p, sa, r;
    longint prod;
    ua = a; ub = b;
    s  = int'(ub % 16);
    p  = 1 << s;
    case (op)
      3'd0: return 16'((ua + ub) % 65536);
      3'd1: return a & b;
      3'd2: return 16'(65535 - ua);
      3'd3: return a;
      3'd4: return a ^ b;
      3'd5: return 16'((longint'(ua) * p) % 65536);
      3'd6: begin
        sa = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
        r  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        return 16'(r);
      end
      default: begin
        prod = longint'(ua) * longint'(ub);
        return 16'(prod % 65536);
      end
    endcase
  endfunction

  function automatic logic [2:0] model_cc(input logic [15:0] r);
    if (r == 0)            return 3'b010;
    else if (r >= 16'h8000) return 3'b100;
    else                   return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, check completion timing and values; poke_mid pulses start mid-multiply.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] i_r,
                        input logic [15:0] b2, input bit poke_mid);
    logic [15:0] exp_r;
    exp_r  = model_alu(op, a, model_op_b(i_r, b2));
    aluk   = op; sr1out = a; ir = i_r; sr2out = b2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    sr1out = 16'($urandom); sr2out = 16'($urandom); ir = 16'($urandom);
    if (op != 3'd7) begin
      check("alu_done", done, 1'b1);
      check("alu_busy", busy, 1'b0);
      check("alu_result", result, exp_r);
      check("alu_nzp", nzp, model_cc(exp_r));
    end else begin
      for (int k = 1; k <= 16; k++) begin
        check("mul_busy", busy, 1'b1);
        check("mul_nodone", done, 1'b0);
        check("mul_hold", result, model_result);
        check("mul_bus_old", data_bus, model_result);
        if (poke_mid && k == 8) begin
          aluk = 3'd0; start = 1'b1;
        end
        if (k == 9) start = 1'b0;
        tick();
      end
      check("mul_done", done, 1'b1);
      check("mul_busy_end", busy, 1'b0);
      check("mul_result", result, exp_r);
      check("mul_nzp", nzp, model_cc(exp_r));
    end
    model_result = exp_r;
    model_nzp    = model_cc(exp_r);
    check("bus_result", data_bus, model_result);
    tick();
    check("done_pulse", done, 1'b0);
    check("result_hold", result, model_result);
  endtask

  initial begin
    bit seen_done;
    logic [15:0] e1, e2;
    reset = 1'b1; start = 1'b0; gate_alu = 1'b1; aluk = 3'd0;
    sr1out = 16'h0; ir = 16'h0; sr2out = 16'h0;
    tb_drv_en = 1'b0; tb_drv_val = 16'h0;
    model_result = 16'h0; model_nzp = 3'b010;
    tick(); tick();
    reset = 1'b0;
    check("rst_result", result, 16'h0000);
    check("rst_nzp", nzp, 3'b010);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    run_op(3'd0, 16'h0005, 16'h003D, 16'h0000, 1'b0);
    check("add_imm_value", result, 16'h0002);
    check("add_imm_nzp", nzp, 3'b001);
    run_op(3'd0, 16'h7FFF, 16'h0000, 16'h0001, 1'b0);
    check("add_ovf_value", result, 16'h8000);
    run_op(3'd2, 16'h00FF, 16'h0000, 16'h0000, 1'b0);
    check("not_value", result, 16'hFF00);
    run_op(3'd6, 16'h8000, 16'h0024, 16'h0000, 1'b0);
    check("sra_value", result, 16'hF800);
    run_op(3'd5, 16'h0001, 16'h0000, 16'h0013, 1'b0);
    check("shl_mod_value", result, 16'h0008);
    run_op(3'd7, 16'h0013, 16'h0000, 16'h0005, 1'b1);
    check("mul_value", result, 16'h005F);
    run_op(3'd5, 16'h0003, 16'h002F, 16'h0000, 1'b0);
    check("shl_value", result, 16'h8000);

    // tri-state release: a second driver must win cleanly when gate_alu is low
    gate_alu = 1'b0; tb_drv_en = 1'b1; tb_drv_val = 16'h5A3C;
    #1;
    check("bus_release", data_bus, 16'h5A3C);
    tb_drv_en = 1'b0; gate_alu = 1'b1;
    #1;
    check("bus_drive", data_bus, 16'h8000);

    // start in the done cycle is accepted
    e1 = model_alu(3'd4, 16'h1234, 16'h00FF);
    e2 = model_alu(3'd1, 16'hF0F0, 16'h0FF0);
    aluk = 3'd4; sr1out = 16'h1234; ir = 16'h0000; sr2out = 16'h00FF; start = 1'b1;
    tick();
    check("b2b_first", result, e1);
    aluk = 3'd1; sr1out = 16'hF0F0; sr2out = 16'h0FF0;
    tick();
    start = 1'b0;
    check("b2b_done", done, 1'b1);
    check("b2b_second", result, e2);
    model_result = e2; model_nzp = model_cc(e2);
    tick();

    for (int n = 0; n < 40; n++)
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom));

    // reset in the middle of a multiply aborts it
    if (model_result == 16'h0) run_op(3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    aluk = 3'd7; sr1out = 16'h00AB; ir = 16'h0000; sr2out = 16'h0107; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_nzp", nzp, 3'b010);
    check("abort_done", done, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", seen_done, 1'b0);
    check("abort_hold", result, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
